if_fetch_unit: RTL and testbench



---
 rtl/if_fetch_unit_if.sv | 20 ++
 rtl/if_fetch_unit.sv | 76 +++++++
 tb/tb_if_fetch_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: instruction-memory, redirect and decode-side signals of the fetch stage.
interface if_fetch_unit_if #(parameter int ADDR_W = 11);
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [31:0]       out_pc;
  modport master (
    output imem_en, imem_addr, out_valid, out_inst, out_pc,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input  imem_en, imem_addr, out_valid, out_inst, out_pc,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: sequential-PC fetch with one-cycle memory, fetch queue and redirect flush.
// Define IF_BUBBLE_CNT_EN to add the perf_bubbles counter port.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 11,
  parameter int          DEPTH    = 2
) (
  input logic clk,
  input logic rst,
  if_fetch_unit_if.master bus
`ifdef IF_BUBBLE_CNT_EN
  ,
  output logic [31:0] perf_bubbles
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]   pc, pending_pc;
  logic          pending;
  logic [CW-1:0] count;
  logic [AW-1:0] head, tail;
  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic          issue, push, pop, valid;
  // count + pending never exceeds DEPTH, so it fits in CW bits
  always_comb begin
    valid = !rst && count != '0;
    issue = !rst && !bus.redirect_valid && (count + CW'(pending) < CW'(DEPTH));
    push = pending && !bus.redirect_valid;
    pop = valid && bus.out_ready;
    bus.imem_en = issue;
    bus.imem_addr = pc[ADDR_W+1:2];
    bus.out_valid = valid;
    bus.out_inst = rst ? '0 : inst_q[head];
    bus.out_pc = rst ? '0 : pc_q[head];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      pending <= 1'b0;
      pending_pc <= '0;
      count <= '0;
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i] <= '0;
      end
    end else if (bus.redirect_valid) begin
      pc <= {bus.redirect_pc[31:2], 2'b00};
      pending <= 1'b0;
      count <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      pending <= issue;
      if (issue) begin
        pending_pc <= pc;
        pc <= pc + 32'd4;
      end
      if (push) begin
        inst_q[tail] <= bus.imem_rdata;
        pc_q[tail] <= pending_pc;
        tail <= tail + AW'(1);
      end
      if (pop) head <= head + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
`ifdef IF_BUBBLE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) perf_bubbles <= '0;
    else if (bus.out_ready && !valid) perf_bubbles <= perf_bubbles + 32'd1;
  end
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed and random stimulus checked per cycle against a transaction-level fetch model.
module tb_if_fetch_unit;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 2;
  typedef struct {
    logic [31:0] pc;
    int          rdy;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  ent_t q[$];
  logic [31:0] mpc = 32'h0;
  logic [31:0] mbub = 32'h0;
  if_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();
`ifdef IF_BUBBLE_CNT_EN
  logic [31:0] perf_bubbles;
`endif
  if_fetch_unit #(.RESET_PC(32'h0), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef IF_BUBBLE_CNT_EN
    ,
    .perf_bubbles(perf_bubbles)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [ADDR_W-1:0] a);
    return 32'h100 + 32'(a);
  endfunction
  always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= mem(bus.imem_addr);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask
  // Every fetch issued in cycle c is deliverable from cycle c+2 until popped or flushed.
  task automatic step(input logic r, input logic d, input logic [31:0] dpc, input logic rdy);
    logic exp_en, exp_val;
    rst = r;
    bus.redirect_valid = d;
    bus.redirect_pc = dpc;
    bus.out_ready = rdy;
    #1;
    exp_en = !r && !d && q.size() < DEPTH;
    exp_val = !r && q.size() > 0 && q[0].rdy <= cyc;
    chk("imem_en", 32'(bus.imem_en), 32'(exp_en));
    if (exp_en) chk("imem_addr", 32'(bus.imem_addr), 32'(mpc[ADDR_W+1:2]));
    chk("out_valid", 32'(bus.out_valid), 32'(exp_val));
    if (exp_val) begin
      chk("out_pc", bus.out_pc, q[0].pc);
      chk("out_inst", bus.out_inst, mem(q[0].pc[ADDR_W+1:2]));
    end else if (r) begin
      chk("rst_out_pc", bus.out_pc, 32'h0);
      chk("rst_out_inst", bus.out_inst, 32'h0);
    end
`ifdef IF_BUBBLE_CNT_EN
    chk("perf_bubbles", perf_bubbles, mbub);
`endif
    if (r) begin
      q.delete();
      mpc = 32'h0;
      mbub = 32'h0;
    end else begin
      if (rdy && !exp_val) mbub++;
      if (d) begin
        q.delete();
        mpc = {dpc[31:2], 2'b00};
      end else begin
        if (exp_val && rdy) void'(q.pop_front());
        if (exp_en) begin
          q.push_back('{mpc, cyc + 2});
          mpc += 32'd4;
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask
  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.out_ready = 1'b1;
    repeat (2) step(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h43, 1'b1);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h80, 1'b1);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h1FFC, 1'b1);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (3000)
      step($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0, $urandom,
           $urandom_range(0, 3) != 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
